platform_mgr: RTL and testbench
===============================

PLATFORM_MGR -- requirements
Module: platform_mgr

Interface
REQ-001 SHALL have no parameters; screen height (480), platform width (58) and slot count (10) are fixed constants.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port frame_tick  input  1  one-cycle pulse per video frame, at vertical blank.
REQ-005 SHALL provide port scroll_amt  input  5  pixels to scroll all platforms downward this frame (0..31).
REQ-006 SHALL provide port plat_x  output  90  packed slot x positions; slot i at bits [9i+8:9i], 9-bit unsigned.
REQ-007 SHALL provide port plat_y  output  90  packed slot y positions; slot i at bits [9i+8:9i], 9-bit unsigned.
REQ-008 SHALL provide port busy  output  1  high while the scroll walk is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse when a scroll walk completes.
REQ-010 SHALL provide port overrun  output  1  one-cycle pulse when frame_tick arrives while busy.
REQ-011 SHALL provide port respawns  output  16  count of platforms recycled since reset.

Function
REQ-012 SHALL implement FSM states IDLE, WALK, FIN; IDLE->WALK on frame_tick; WALK->FIN after slot 9; FIN->IDLE unconditionally.
REQ-013 SHALL latch scroll_amt into an internal register on the IDLE->WALK transition; later scroll_amt changes have no effect on the current walk.
REQ-014 SHALL in WALK process exactly one slot per cycle, index 0 to 9 ascending, giving 10 WALK cycles.
REQ-015 SHALL for each slot compute a 10-bit sum = y + latched amount; if sum < 480, slot y gets sum[8:0] and x is unchanged.
REQ-016 SHALL if sum >= 480, respawn the slot: y gets (sum - 480)[8:0], x gets the candidate from REQ-018, respawns increments.
REQ-017 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1) that advances every cycle, including IDLE.
REQ-018 SHALL form candidate x from the low 9 LFSR bits r: if r <= 450, candidate = r; otherwise candidate = r - 256. Candidate is always in 0..450.
REQ-019 SHALL saturate respawns at 0xFFFF; it never wraps.
REQ-020 SHALL assert busy in WALK and FIN, and deassert it in IDLE.
REQ-021 SHALL pulse done for exactly one cycle, in FIN.
REQ-022 SHALL when frame_tick is high in WALK or FIN, ignore it (no restart, no queuing) and pulse overrun in that same cycle.
REQ-023 SHALL with latched amount 0, still perform the full walk and done pulse, with no position changes and no respawns.
REQ-024 SHALL update plat_x/plat_y registers in place during WALK; consumers sample them after done.
REQ-025 SHALL when frame_tick coincides with rst, give rst priority; no walk starts.

Reset
REQ-026 SHALL on rst set state IDLE, and set busy, done and overrun to 0.
REQ-027 SHALL on rst clear respawns and the latched amount to 0, and load the LFSR with 0xACE1.
REQ-028 SHALL on rst set slot i to x = 40 + 45*i and y = 48*i (slot 9: x=445, y=432).
REQ-029 SHALL when rst is asserted mid-walk, abort the walk and reinitialise fully per REQ-026 to REQ-028 on the next edge, with no done pulse.

Verification
REQ-030 SHALL cover: reset, then frame_tick with scroll_amt=10 -> busy for 11 cycles, done 11 cycles after the tick; slot 0 y=10, slot 9 y=442; respawns=0.
REQ-031 SHALL cover: from reset, four frames of scroll_amt=12 (slot 9 y=480 on the 4th) -> slot 9 y=0, slot 9 x in 0..450 and equal to the REQ-018 model; respawns=1.
REQ-032 SHALL cover: a second frame_tick 3 cycles after the first -> overrun pulses once, exactly one done, positions reflect a single scroll.
REQ-033 SHALL cover: frame_tick with scroll_amt=0 -> done after 11 cycles, all positions equal their reset values.
REQ-034 SHALL cover: rst asserted at WALK cycle 5 -> no done; next cycle all slots at reset values, respawns=0, busy=0.
REQ-035 SHALL cover: long random run against a reference model (scroll_amt 0..31) -> every y < 480, every x <= 450, respawns matches the model.

Source files
------------

// File: rtl/platform_mgr.sv
// Platform slot manager: scrolls ten platforms downward once per frame
// and recycles any that fall off the bottom to a pseudo-random column.
module platform_mgr (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [4:0]  scroll_amt,
  output logic [89:0] plat_x,
  output logic [89:0] plat_y,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] respawns
);

  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [8:0] X_MAX    = 9'd450;
  localparam int         SLOTS    = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_idx;
  logic [4:0]  r_amt;
  logic [15:0] r_lfsr;
  logic [15:0] r_resp;
  logic [8:0]  r_x [SLOTS];
  logic [8:0]  r_y [SLOTS];

  logic        w_fb;
  logic [15:0] w_lfsr_nxt;
  logic [8:0]  w_r;
  logic [8:0]  w_cand;
  logic [8:0]  w_ycur;
  logic [9:0]  w_sum;
  logic        w_wrap;
  logic [8:0]  w_y_wrap;

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11
  assign w_fb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr_nxt = {w_fb, r_lfsr[15:1]};

  // Fold out-of-range values back into the visible column range
  assign w_r    = r_lfsr[8:0];
  assign w_cand = (w_r <= X_MAX) ? w_r : (w_r - 9'd256);

  assign w_ycur   = r_y[r_idx];
  assign w_sum    = {1'b0, w_ycur} + {5'd0, r_amt};
  assign w_wrap   = (w_sum >= SCREEN_H);
  assign w_y_wrap = 9'(w_sum - SCREEN_H);

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);
  assign overrun  = frame_tick & busy;
  assign respawns = r_resp;

  // Free-running random source, advances every cycle
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= w_lfsr_nxt;
  end

  // Walk FSM: one slot per cycle, then a single FIN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_amt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_state <= S_WALK;
            r_amt   <= scroll_amt;
            r_idx   <= 4'd0;
          end
        end
        S_WALK: begin
          if (r_idx == 4'(SLOTS - 1)) r_state <= S_FIN;
          else                        r_idx   <= r_idx + 4'd1;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slot positions, updated in place during the walk
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_x[i] <= 9'(40 + 45 * i);
        r_y[i] <= 9'(48 * i);
      end
    end else if (r_state == S_WALK) begin
      if (w_wrap) begin
        r_y[r_idx] <= w_y_wrap;
        r_x[r_idx] <= w_cand;
      end else begin
        r_y[r_idx] <= w_sum[8:0];
      end
    end
  end

  // Saturating recycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp <= 16'd0;
    end else if (r_state == S_WALK && w_wrap && r_resp != 16'hFFFF) begin
      r_resp <= r_resp + 16'd1;
    end
  end

  // Flatten slot arrays onto the packed output buses
  always_comb begin
    plat_x = '0;
    plat_y = '0;
    for (int i = 0; i < SLOTS; i++) begin
      plat_x[9*i +: 9] = r_x[i];
      plat_y[9*i +: 9] = r_y[i];
    end
  end

endmodule

// File: tb/tb_platform_mgr.sv
// Bench for platform_mgr: table of frames with hand-computed results,
// hand-written corner sequences and a long randomised run vs a model.
module tb_platform_mgr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [4:0]  scroll_amt = 5'd0;
  logic [89:0] plat_x;
  logic [89:0] plat_y;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] respawns;

  platform_mgr dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .scroll_amt (scroll_amt),
    .plat_x     (plat_x),
    .plat_y     (plat_y),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .respawns   (respawns)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [15:0] step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  function automatic logic [8:0] cand(input logic [8:0] r);
    if (r <= 9'd450) return r;
    return r - 9'd256;
  endfunction

  // Reference copy of the random source, clocked alongside the DUT
  logic [15:0] bl;
  always @(posedge clk) bl <= rst ? 16'hACE1 : step(bl);

  int mx [10];
  int my [10];
  int mresp;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      mx[i] = 40 + 45 * i;
      my[i] = 48 * i;
    end
    mresp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int bad_slots();
    int b;
    b = 0;
    for (int i = 0; i < 10; i++) begin
      if (int'(plat_x[9*i +: 9]) != mx[i] ||
          int'(plat_y[9*i +: 9]) != my[i]) b++;
    end
    return b;
  endfunction

  function automatic int out_of_range();
    int b;
    b = 0;
    for (int i = 0; i < 10; i++) begin
      if (plat_x[9*i +: 9] > 9'd450) b++;
      if (plat_y[9*i +: 9] >= 9'd480) b++;
    end
    return b;
  endfunction

  // Issue one frame tick, update the model, observe 20 cycles
  task automatic run_frame(input int amt, input int ov_at,
                           output int bc, output int dc,
                           output int dpos, output int oc);
    logic [15:0] l;
    int sum;
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_amt = amt[4:0];
    l = bl;
    for (int k = 0; k < 10; k++) begin
      l = step(l);
      sum = my[k] + amt;
      if (sum >= 480) begin
        my[k] = sum - 480;
        mx[k] = int'(cand(l[8:0]));
        if (mresp < 65535) mresp++;
      end else begin
        my[k] = sum;
      end
    end
    bc = 0; dc = 0; dpos = 0; oc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      frame_tick = (c == ov_at);
      scroll_amt = ~amt[4:0];
      #1;
      if (busy) bc++;
      if (done) begin dc++; dpos = c; end
      if (overrun) oc++;
    end
  endtask

  typedef struct {
    bit rst_first;
    int amt;
    int y0;
    int y9;
    int resp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int bc, dc, dp, oc, cnt;
    string nm;

    tbl[0] = '{1'b1, 10, 10, 442, 0};
    tbl[1] = '{1'b1, 12, 12, 444, 0};
    tbl[2] = '{1'b0, 12, 24, 456, 0};
    tbl[3] = '{1'b0, 12, 36, 468, 0};
    tbl[4] = '{1'b0, 12, 48,   0, 1};
    tbl[5] = '{1'b1,  0,  0, 432, 0};
    tbl[6] = '{1'b0, 31, 31, 463, 0};
    tbl[7] = '{1'b0, 31, 62,  14, 1};

    do_reset();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_respawns", int'(respawns), 0);
    chk("rst_slot9_x", int'(plat_x[81 +: 9]), 445);
    chk("rst_slot9_y", int'(plat_y[81 +: 9]), 432);
    chk("rst_pos", bad_slots(), 0);

    for (int v = 0; v < 8; v++) begin
      if (tbl[v].rst_first) do_reset();
      run_frame(tbl[v].amt, 0, bc, dc, dp, oc);
      nm = $sformatf("v%0d", v);
      chk({nm, "_busy_cycles"}, bc, 11);
      chk({nm, "_done_count"}, dc, 1);
      chk({nm, "_done_cycle"}, dp, 11);
      chk({nm, "_overrun"}, oc, 0);
      chk({nm, "_y0"}, int'(plat_y[0 +: 9]), tbl[v].y0);
      chk({nm, "_y9"}, int'(plat_y[81 +: 9]), tbl[v].y9);
      chk({nm, "_respawns"}, int'(respawns), tbl[v].resp);
      chk({nm, "_pos_model"}, bad_slots(), 0);
      chk({nm, "_range"}, out_of_range(), 0);
    end

    // Second tick three cycles into a walk
    do_reset();
    run_frame(10, 3, bc, dc, dp, oc);
    chk("ovr_pulses", oc, 1);
    chk("ovr_done_count", dc, 1);
    chk("ovr_done_cycle", dp, 11);
    chk("ovr_y0", int'(plat_y[0 +: 9]), 10);
    chk("ovr_y9", int'(plat_y[81 +: 9]), 442);
    chk("ovr_pos_model", bad_slots(), 0);

    // Tick coinciding with reset must not start a walk
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (busy || done) cnt++;
      @(negedge clk);
    end
    chk("rsttick_busy", cnt, 0);
    chk("rsttick_pos", bad_slots(), 0);

    // Reset in WALK cycle 5 after moving away from reset state
    run_frame(31, 0, bc, dc, dp, oc);
    run_frame(31, 0, bc, dc, dp, oc);
    chk("pre_abort_respawns", int'(respawns), 1);
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_amt = 5'd20;
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      #1;
      if (done) cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_respawns", int'(respawns), 0);
    chk("abort_pos", bad_slots(), 0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("abort_no_done", cnt, 0);

    // Long randomised run against the model
    do_reset();
    for (int f = 0; f < 300; f++) begin
      int a, ov;
      a  = int'($urandom_range(0, 31));
      ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 0;
      run_frame(a, ov, bc, dc, dp, oc);
      nm = $sformatf("rnd%0d", f);
      chk({nm, "_done"}, dc, 1);
      chk({nm, "_overrun"}, oc, (ov != 0) ? 1 : 0);
      chk({nm, "_pos_model"}, bad_slots(), 0);
      chk({nm, "_range"}, out_of_range(), 0);
      chk({nm, "_respawns"}, int'(respawns), mresp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
